// File: rtl/seg_display_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// seg_arb_pkg
// Shared types and helpers for the seven-segment display arbiter.
//   state_t  : arbiter state (IDLE / OWNED)
//   pick_t   : result of a round-robin search (valid bit + winning index)
//   rr_pick  : round-robin search starting one above the last owner
// ---------------------------------------------------------------------------
package seg_arb_pkg;

  // The search helper works on a fixed-width request vector so it can live
  // in a package; callers zero-extend their narrower request vectors.
  localparam int MAX_REQ = 32;
  localparam int PICK_W  = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // Returns the first asserted request found searching upward from last+1,
  // wrapping modulo num_req. The last owner itself is visited last, so it
  // only wins when nobody else is asking.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input int unsigned        num_req,
                                    input int unsigned        last);
    pick_t       p;
    int unsigned cand;
    p = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      cand = (last + k) % num_req;
      if (k <= num_req && !p.valid && req[cand[PICK_W-1:0]]) begin
        p.valid = 1'b1;
        p.idx   = cand[PICK_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter_if
// Bundles the requester-facing and display-facing signals of the arbiter.
//   req / req_encoded / req_dp : per-requester request level and frame
//   grant / owner / busy       : ownership status
//   encoded / digit_point      : frame forwarded to seven_segment
// Modports: master = requester/display side, slave = arbiter.
// ---------------------------------------------------------------------------
interface seg_display_arbiter_if #(
  parameter int NUM_REQ      = 2,
  parameter int NUM_SEGMENTS = 8
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                   req;
  logic [NUM_REQ-1:0][NUM_SEGMENTS-1:0][3:0] req_encoded;
  logic [NUM_REQ-1:0][NUM_SEGMENTS-1:0] req_dp;
  logic [NUM_REQ-1:0]                   grant;
  logic [IDX_W-1:0]                     owner;
  logic                                 busy;
  logic [NUM_SEGMENTS-1:0][3:0]         encoded;
  logic [NUM_SEGMENTS-1:0]              digit_point;

  modport master (
    output req, req_encoded, req_dp,
    input  grant, owner, busy, encoded, digit_point
  );

  modport slave (
    input  req, req_encoded, req_dp,
    output grant, owner, busy, encoded, digit_point
  );

endinterface

// File: rtl/seg_display_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick.
//   req   : request levels
//   last  : index of the most recent owner (search starts at last+1)
//   valid : some request is asserted
//   idx   : winning requester index
// Supports up to seg_arb_pkg::MAX_REQ requesters.
// ---------------------------------------------------------------------------
module rr_arbiter
  import seg_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [MAX_REQ-1:0] req_ext;
  pick_t              pick;

  // Widen the request vector to the helper's fixed width and run the search.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    pick                   = rr_pick(req_ext, NUM_REQ, 32'(last));
    valid                  = pick.valid;
    idx                    = IDX_W'(pick.idx);
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
// Shares one seven-segment display between NUM_REQ requesters. Ownership is
// round-robin with a minimum tenure of HOLD_CYCLES clocks; an owner that
// drops its request releases immediately.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of seg_display_arbiter_if (requests in, grant/owner/
//           busy status and the selected frame out)
// ---------------------------------------------------------------------------
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int NUM_SEGMENTS = 8,
  parameter int HOLD_CYCLES  = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  seg_display_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic [IDX_W-1:0]   last;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               expired;

  logic               nxt_valid;
  logic               nxt_new;
  logic [IDX_W-1:0]   nxt_idx;
  logic [NUM_REQ-1:0] nxt_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req   (bus.req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign expired = (hold_cnt == CNT_MAX);

  // Decide who owns the display after this edge. nxt_new marks the start of
  // a fresh tenure. When the owner has expired and is the only requester,
  // the pick wraps back to the owner itself, so it simply keeps the display.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_new   = 1'b0;
    nxt_idx   = last;
    nxt_grant = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          nxt_valid = 1'b1;
          nxt_new   = 1'b1;
          nxt_idx   = pick_idx;
        end
      end
      OWNED: begin
        if (!bus.req[last]) begin
          if (pick_valid) begin
            nxt_valid = 1'b1;
            nxt_new   = 1'b1;
            nxt_idx   = pick_idx;
          end
        end else if (expired && pick_idx != last) begin
          nxt_valid = 1'b1;
          nxt_new   = 1'b1;
          nxt_idx   = pick_idx;
        end else begin
          nxt_valid = 1'b1;
        end
      end
      default: ;
    endcase
    if (nxt_valid) begin
      nxt_grant[nxt_idx] = 1'b1;
    end
  end

  // State, tenure counter, round-robin pointer and all registered outputs.
  // The frame follows the next owner's live data every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      hold_cnt        <= '0;
      last            <= IDX_W'(NUM_REQ - 1);
      bus.owner       <= '0;
      bus.grant       <= '0;
      bus.busy        <= 1'b0;
      bus.encoded     <= '0;
      bus.digit_point <= '0;
    end else begin
      state     <= nxt_valid ? OWNED : IDLE;
      bus.grant <= nxt_grant;
      bus.busy  <= nxt_valid;
      if (nxt_new) begin
        hold_cnt  <= '0;
        last      <= nxt_idx;
        bus.owner <= nxt_idx;
      end else if (!nxt_valid) begin
        hold_cnt  <= '0;
      end else if (!expired) begin
        hold_cnt  <= hold_cnt + CNT_W'(1);
      end
      if (nxt_valid) begin
        bus.encoded     <= bus.req_encoded[nxt_idx];
        bus.digit_point <= bus.req_dp[nxt_idx];
      end else begin
        bus.encoded     <= '0;
        bus.digit_point <= '0;
      end
    end
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares one multi-digit seven-segment display between several requesters, such as free-running counters, button-driven values and status words. Each requester presents a full display frame (hex digits plus decimal points). The block grants ownership round-robin with a minimum hold time, so a digit pattern stays readable before another requester can preempt it. It sits directly upstream of `seven_segment`: its `encoded` and `digit_point` outputs drive that block's inputs unchanged.

## Interface
- `NUM_REQ`, default 2: number of requesters; minimum 2.
- `NUM_SEGMENTS`, default 8: digits per frame; must match the downstream `seven_segment`.
- `HOLD_CYCLES`, default 100_000_000: minimum tenure in clocks, which is 1 s at a 10 ns clock; minimum 2.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req`, input, `[NUM_REQ-1:0]`: level request; held high while the requester wants the display.
- `req_encoded`, input, `[NUM_REQ-1:0][NUM_SEGMENTS-1:0][3:0]`: per-requester hex digits.
- `req_dp`, input, `[NUM_REQ-1:0][NUM_SEGMENTS-1:0]`: per-requester decimal points.
- `grant`, output, `[NUM_REQ-1:0]`: one-hot owner, or zero when idle.
- `owner`, output, `[$clog2(NUM_REQ)-1:0]`: index of the current or most recent owner.
- `busy`, output, 1: high while any requester is granted.
- `encoded`, output, `[NUM_SEGMENTS-1:0][3:0]`: frame sent to the display.
- `digit_point`, output, `[NUM_SEGMENTS-1:0]`: decimal points sent to the display.

## Operation
- The state machine has two states, IDLE and OWNED.
- **Reset values:** `grant=0`, `busy=0`, `owner=0`, `encoded=0`, `digit_point=0`, hold counter 0, state IDLE.
- **Round-robin pointer:**
  - The pointer is `last`; reset sets it to `NUM_REQ-1`, so requester 0 wins first.
  - The pick is the first asserted `req` searching upward from `last+1`, modulo `NUM_REQ`.
- **IDLE:**
  - Outputs show all-zero digits with decimal points off.
  - If any `req` is high, grant the pick and go to OWNED.
  - On that grant: load the hold counter with 0, set `last` and `owner` to the pick, and assert `busy`.
- **OWNED:**
  - The hold counter increments each cycle and saturates at `HOLD_CYCLES-1`. "Expired" means counter == `HOLD_CYCLES-1`.
  - Other requests are ignored until expiry; the owner cannot be preempted before then.
- **Owner drops `req`, at any counter value:** release the display that same edge.
  - If another request is pending, grant the pick; its tenure starts with the counter at 0.
  - Otherwise go to IDLE: `grant=0`, `busy=0`, and `encoded`/`digit_point` go to 0. `owner` keeps its value.
- **Expired with owner still requesting:**
  - If any other `req` is high, grant the pick, which excludes the current owner because the search starts at `last+1`. Counter resets to 0.
  - If no other request is pending, the owner keeps the display and the counter stays saturated. Any later request then takes over on its first cycle high.
- **Data path:** every cycle, `encoded <= req_encoded[next_owner]` and `digit_point <= req_dp[next_owner]`. The owner's live data is therefore tracked continuously, not snapshotted at grant.
- **Simultaneous new requests:** round-robin order from `last+1` decides.
- **Reset during OWNED:** return to the reset values on the next edge, including `last=NUM_REQ-1`.

## Timing
- **Grant latency:** a `req` rising at edge N while IDLE gives `grant`/`busy` high after edge N+1.
- **Data latency:** `encoded` reflects the new owner's data from the same edge as the grant. Thereafter the owner's data reaches the output one cycle after it is presented.
- **Release latency:** `req` low sampled at edge N gives a new grant, or IDLE, after edge N.
- **Minimum tenure:** with contention, exactly `HOLD_CYCLES` cycles of `grant` from grant edge to handoff edge.
- **Grant width:** `grant` is one-hot or zero on every cycle; no cycle has two bits high.
- **Reset takes priority** over all transitions in the same cycle.

## Structure
- **Package `seg_arb_pkg`:**
  - `state_t` enum with values IDLE and OWNED.
  - Function `rr_pick(req, last)`, which returns a valid bit and an index.
- **Sub-module `rr_arbiter`:** combinational round-robin pick with parameter `NUM_REQ`; it is instantiated once.
- **Top level:** holds the state machine, hold counter, `last` register and output registers.
- **Hold counter width:** `$clog2(HOLD_CYCLES)`.

## Test plan
Run all scenarios with `NUM_REQ=2`, `NUM_SEGMENTS=8`, `HOLD_CYCLES=4` unless stated.
- **Reset:** assert `reset` for 3 cycles with `req=2'b11` → `grant=0`, `busy=0`, `encoded=0` throughout. After release, `grant=2'b01` one cycle later.
- **Single requester:** raise `req[1]` only, with frame `32'h12345678` and `dp=8'h01` → after one edge `grant=2'b10`, `owner=1`, `encoded=32'h12345678`. Frame changes appear one cycle later.
- **Contention:** hold both `req` high → grant alternates `01`,`10`,`01` with exactly 4 cycles per tenure. The `encoded` output switches on the same edges.
- **Early release:**
  - Requester 0 owns; it drops `req` at counter 1 while `req[1]` is high → `grant=2'b10` on the next edge.
  - With `req[1]` low instead → IDLE, `busy=0`, `encoded=0`.
- **Late arrival after expiry:** requester 0 alone for 10 cycles, then `req[1]` rises → `grant=2'b10` one edge later, with no waiting for the hold time.
- **Mid-tenure reset and 3-requester rotation:**
  - Reset in OWNED at counter 2 → reset values, and requester 0 is granted first afterwards.
  - With `NUM_REQ=3` and all requesting, the order is 0,1,2,0.
